action_event_tx: RTL and testbench
==================================

# action_event_tx

Serial transmitter for the action channel. It watches the 8-bit action code produced by the action regulator, queues every change in a small FIFO, and sends each queued code as a framed, parity-protected bit stream on one output pin (uio_out[3]). An external observer such as a logic analyser, MCU or FPGA monitor can then log the creature's behaviour history without sampling the full parallel bus. It runs in the model clock domain, alongside the other physiological subsystems.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- BIT_TICKS, 1: clk_model cycles per transmitted bit, 1..15.
- clk_model  in  1  model clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- action  in  8  current action code (synchronous to clk_model).
- enable  in  1  1 = change detection active; 0 = no new pushes.
- clr_overflow  in  1  synchronous clear of the overflow flag.
- tx  out  1  serial line, idle high.
- busy  out  1  1 while a frame is in progress (state != IDLE).
- overflow  out  1  sticky: a change was dropped because the FIFO was full.
- fifo_level  out  $clog2(DEPTH)+1  number of queued codes.

## Operation
- Change detector: prev_action register, reset 8'h00, loaded with action on every edge regardless of enable. push = enable & (action != prev_action).
- FIFO: circular buffer with wrapping read/write pointers and a level counter.
  - push when not full: write action, level +1.
  - push when full: code dropped, level unchanged, overflow set at that edge.
  - push and pop on the same edge: both take effect and level is unchanged. This applies when full as well; the push is then accepted.
- overflow: set by a dropped push, cleared by clr_overflow. If both happen on the same edge, set wins.
- Frame, LSB first: start bit 0, data[0..7], parity bit, stop bit 1. That is 11 bits, each held for BIT_TICKS cycles. Parity is even: the XOR of the 8 data bits, so the total count of ones over data+parity is even.
- FSM: IDLE, START, DATA, PARITY, STOP. A bit-tick counter counts 0..BIT_TICKS-1 and a bit index counts 0..7.
  - IDLE: if level>0, pop the head into the shift register and go to START. Otherwise stay.
  - START: tx=0 for BIT_TICKS cycles, then go to DATA.
  - DATA: tx = shift[0]; shift right after each bit; go to PARITY after bit 7.
  - PARITY: tx = stored parity, computed at load.
  - STOP: tx=1 for BIT_TICKS cycles. At the last tick, if level>0, pop and go straight to START (back-to-back frames). Otherwise go to IDLE.
- tx is driven from a register; there is no combinational path from action to tx.
- enable only gates pushes. Queued codes and a frame already in flight always complete.

## Timing
- Reset values: tx=1, busy=0, overflow=0, fifo_level=0, FSM=IDLE, prev_action=0, pointers=0.
- Reset asserted mid-frame: tx=1 immediately (asynchronous) and the FIFO contents are discarded.
- Action change present before edge N: pushed at edge N, so fifo_level rises after N.
- With FSM in IDLE, the pop happens at edge N+1: after N+1, tx=0, busy=1 and fifo_level has decremented.
- Frame length: exactly 11*BIT_TICKS cycles from the tx falling edge to the end of the stop bit.
- Back-to-back frames: the next start bit follows the stop bit with zero idle cycles.
- Frame end with an empty FIFO: busy falls on the edge that ends the stop bit.
- An action that changes and then returns within consecutive cycles produces two pushes, one per change.
- The first change after reset from 8'h00 is pushed. If action is already nonzero at the first edge after reset release, that value is pushed.

## Test plan
- Single frame, BIT_TICKS=2: action 00->07 at edge 10. tx low from edge 11. Then data bits 1,1,1,0,0,0,0,0, parity 1, stop 1, each 2 cycles. busy falls at edge 33. fifo_level goes 1 then 0.
- Back-to-back, BIT_TICKS=1: changes to 05, 06, 07 on three consecutive edges. Three frames with no idle cycles between them, data in order 05, 06, 07, parities 0, 0, 1.
- Overflow, DEPTH=4, BIT_TICKS=4: six changes on consecutive edges starting from idle. The first pops immediately and the next four fill the FIFO. The 6th change is dropped and overflow=1. Frames carry changes 1-5 only. clr_overflow then clears the flag, and a simultaneous clr_overflow with a drop leaves overflow=1.
- Full plus pop, same edge: FIFO full and a frame ending as a new change arrives. The push is accepted, fifo_level stays at 4 and overflow stays 0.
- enable=0: action toggles 10 times and no frames are sent. Re-enabling with action stable sends nothing. The next change is sent.
- Reset mid-frame: assert rst_n low during DATA. tx=1, busy=0 and fifo_level=0 without waiting for a clock edge. After release, the next change transmits a clean frame.

Source files
------------

// File: rtl/action_event_tx.sv
// action_event_tx: queues every change of the action code and sends each one as an
// 11-bit frame (start, 8 data bits LSB first, even parity, stop) on a single serial line.
module action_event_tx #(
    parameter int DEPTH     = 4,
    parameter int BIT_TICKS = 1
) (
    input  logic                     clk_model,
    input  logic                     rst_n,
    input  logic [7:0]               action,
    input  logic                     enable,
    input  logic                     clr_overflow,
    output logic                     tx,
    output logic                     busy,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAST = 4'(BIT_TICKS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem [DEPTH];
    logic [7:0]    prev_q, prev_d, shift_q, shift_d;
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]   level_q, level_d;
    logic [3:0]    tick_q, tick_d;
    logic [2:0]    idx_q, idx_d;
    logic          par_q, par_d, overflow_q, overflow_d, tx_q, tx_d;
    logic          last, push, pop, accept;

    always_comb begin
        last       = tick_q == LAST;
        push       = enable && action != prev_q;
        pop        = level_q != '0 && (state_q == IDLE || (state_q == STOP && last));
        // a pop on the same edge frees a slot, so a push into a full FIFO is still accepted
        accept     = push && (level_q != (AW+1)'(DEPTH) || pop);
        prev_d     = action;
        wr_d       = accept ? wr_q + 1'b1 : wr_q;
        rd_d       = pop ? rd_q + 1'b1 : rd_q;
        level_d    = level_q + (AW+1)'(accept) - (AW+1)'(pop);
        overflow_d = (push && !accept) || (overflow_q && !clr_overflow);
        state_d    = state_q;
        tick_d     = last ? '0 : tick_q + 1'b1;
        idx_d      = idx_q;
        shift_d    = shift_q;
        par_d      = par_q;
        case (state_q)
            IDLE:    tick_d = '0;
            START:   if (last) state_d = DATA;
            DATA: if (last) begin
                shift_d = shift_q >> 1;
                idx_d   = idx_q + 1'b1;
                if (idx_q == 3'd7) state_d = PARITY;
            end
            PARITY:  if (last) state_d = STOP;
            STOP:    if (last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (pop) begin
            state_d = START;
            shift_d = mem[rd_q];
            par_d   = ^mem[rd_q];
            tick_d  = '0;
        end
        tx_d = state_d == START  ? 1'b0 :
               state_d == DATA   ? shift_d[0] :
               state_d == PARITY ? par_d : 1'b1;
    end

    always_ff @(posedge clk_model or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            prev_q     <= '0;
            shift_q    <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            level_q    <= '0;
            tick_q     <= '0;
            idx_q      <= '0;
            par_q      <= 1'b0;
            overflow_q <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            shift_q    <= shift_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            level_q    <= level_d;
            tick_q     <= tick_d;
            idx_q      <= idx_d;
            par_q      <= par_d;
            overflow_q <= overflow_d;
            tx_q       <= tx_d;
        end
    end

    always_ff @(posedge clk_model) begin
        if (accept) mem[wr_q] <= action;
    end

    assign tx         = tx_q;
    assign busy       = state_q != IDLE;
    assign overflow   = overflow_q;
    assign fifo_level = level_q;
endmodule

// File: tb/tb_action_event_tx.sv
// tb_action_event_tx: directed stimulus for action_event_tx, checked every cycle against
// a queue-based frame model, plus hand-computed expectations for the key scenarios.
module tb_action_event_tx;
    localparam int DEPTH = 4;
    localparam int BT    = 2;
    localparam int FL    = 11 * BT;

    logic       clk_model = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b1;
    logic       clr_overflow = 1'b0;
    logic [7:0] action = 8'h00;
    logic       tx, busy, overflow;
    logic [2:0] fifo_level;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    action_event_tx #(.DEPTH(DEPTH), .BIT_TICKS(BT)) dut (
        .clk_model(clk_model), .rst_n(rst_n), .action(action), .enable(enable),
        .clr_overflow(clr_overflow), .tx(tx), .busy(busy), .overflow(overflow),
        .fifo_level(fifo_level)
    );

    always #5 clk_model = ~clk_model;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: pending codes, sticky overflow and the frame currently on the line
    byte unsigned q[$];
    byte unsigned m_sent[$];
    logic [7:0]   m_prev = 8'h00;
    logic [7:0]   m_data = 8'h00;
    bit           m_ovf = 1'b0;
    bit           m_act = 1'b0;
    int           m_cnt = 0;
    bit           pushv, ending, popv, full;

    always @(posedge clk_model or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_prev = 8'h00;
            m_ovf  = 1'b0;
            m_act  = 1'b0;
            m_cnt  = 0;
        end else begin
            pushv  = enable && action != m_prev;
            ending = m_act && m_cnt == FL - 1;
            popv   = (!m_act || ending) && q.size() > 0;
            m_prev = action;
            if (m_act) begin
                m_cnt++;
                if (ending) m_act = 1'b0;
            end
            if (popv) begin
                m_data = q.pop_front();
                m_sent.push_back(m_data);
                m_act = 1'b1;
                m_cnt = 0;
            end
            full = q.size() >= DEPTH;
            if (pushv && !full) q.push_back(action);
            if (pushv && full) m_ovf = 1'b1;
            else if (clr_overflow) m_ovf = 1'b0;
        end
    end

    function automatic logic exp_tx();
        int b;
        if (!m_act) return 1'b1;
        b = m_cnt / BT;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_data[b-1];
        if (b == 9) return ^m_data;
        return 1'b1;
    endfunction

    always @(negedge clk_model) begin
        if (chk_en) begin
            chk("model_tx", tx, exp_tx());
            chk("model_busy", busy, m_act);
            chk("model_overflow", overflow, m_ovf);
            chk("model_level", fifo_level, q.size());
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk_model);
        #1;
    endtask

    logic [10:0] f1 = 11'b11000001110;
    byte unsigned exp3 [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h88};
    int base;
    int first_idle;

    initial begin
        step(2);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_level", fifo_level, 0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        step(3);

        // single frame of 0x07
        action = 8'h07;
        step(1);
        chk("t1_level_push", fifo_level, 1);
        chk("t1_tx_idle", tx, 1);
        step(1);
        chk("t1_busy_pop", busy, 1);
        chk("t1_level_pop", fifo_level, 0);
        for (int i = 0; i < 11; i++) begin
            chk("t1_frame_bit", tx, f1[i]);
            step(2);
        end
        chk("t1_busy_end", busy, 0);
        chk("t1_tx_end", tx, 1);
        step(2);

        // back-to-back 05, 06, 07
        base = m_sent.size();
        action = 8'h05;
        step(1);
        action = 8'h06;
        step(1);
        action = 8'h07;
        first_idle = -1;
        for (int i = 0; i < 80; i++) begin
            if (!busy && first_idle < 0) first_idle = i;
            step(1);
        end
        chk("t2_busy_span", first_idle, 66);
        chk("t2_count", m_sent.size() - base, 3);
        chk("t2_d0", m_sent[base], 8'h05);
        chk("t2_d1", m_sent[base+1], 8'h06);
        chk("t2_d2", m_sent[base+2], 8'h07);

        // overflow, clear, clear-vs-drop, then full plus pop
        base = m_sent.size();
        action = 8'h11; step(1);
        action = 8'h22; step(1);
        action = 8'h33; step(1);
        action = 8'h44; step(1);
        action = 8'h55; step(1);
        action = 8'h66; step(1);
        chk("t3_ovf_set", overflow, 1);
        chk("t3_level_full", fifo_level, 4);
        clr_overflow = 1'b1;
        step(1);
        chk("t3_ovf_clr", overflow, 0);
        action = 8'h77;
        step(1);
        chk("t3_drop_beats_clr", overflow, 1);
        chk("t3_level_still_full", fifo_level, 4);
        step(1);
        chk("t3_ovf_clr2", overflow, 0);
        clr_overflow = 1'b0;
        step(14);
        action = 8'h88;
        step(1);
        chk("t4_level_full_pop", fifo_level, 4);
        chk("t4_ovf_clear", overflow, 0);
        chk("t4_busy", busy, 1);
        step(100);
        chk("t3_count", m_sent.size() - base, 6);
        for (int i = 0; i < 6; i++) chk("t3_data", m_sent[base+i], exp3[i]);

        // enable gating
        base = m_sent.size();
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            action = (i % 2) ? 8'hA5 : 8'h5A;
            step(1);
        end
        chk("t5_no_busy", busy, 0);
        chk("t5_no_level", fifo_level, 0);
        action = 8'h3C;
        step(2);
        enable = 1'b1;
        step(3);
        chk("t5_reenable_busy", busy, 0);
        chk("t5_reenable_level", fifo_level, 0);
        action = 8'h3D;
        step(2);
        chk("t5_change_busy", busy, 1);
        step(25);
        chk("t5_count", m_sent.size() - base, 1);
        chk("t5_data", m_sent[base], 8'h3D);

        // asynchronous reset mid-frame
        action = 8'hF0;
        step(1);
        action = 8'hF1;
        step(7);
        chk("t6_in_frame", busy, 1);
        #2;
        rst_n  = 1'b0;
        action = 8'h00;
        #1;
        chk("t6_rst_tx", tx, 1);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_level", fifo_level, 0);
        step(2);
        rst_n = 1'b1;
        step(2);
        base = m_sent.size();
        action = 8'h81;
        step(1);
        chk("t6_level_after", fifo_level, 1);
        step(25);
        chk("t6_busy_end", busy, 0);
        chk("t6_count", m_sent.size() - base, 1);
        chk("t6_data", m_sent[base], 8'h81);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
